// File: rtl/tx_voq_scheduler.sv
// tx_voq_scheduler: picks one ingress VOQ head at a time and offers its start
// pointer to the TX MAC. It holds the offer until the MAC accepts it, then
// follows the MAC ready handshake (drop, then rise) to track the frame in service.
// A watchdog stops a single frame from holding the egress port forever.
// Optional build macro: TX_SCHED_STRICT_PRIO_EN. When it is defined, the
// lowest-index valid port wins. When it is not defined, arbitration is
// round-robin starting after the last granted port.
module tx_voq_scheduler #(
    parameter int NUM_PORTS   = 4,
    parameter int VOQ_DEPTH   = 64,
    parameter int TIMEOUT_CYC = 4096,
    localparam int PTR_W      = $clog2(VOQ_DEPTH),
    localparam int GNT_W      = $clog2(NUM_PORTS)
) (
    input  logic                       switch_clk,
    input  logic                       switch_rst_n,
    input  logic [NUM_PORTS-1:0]       req_valid_i,
    input  logic [NUM_PORTS*PTR_W-1:0] req_ptr_i,
    output logic [NUM_PORTS-1:0]       req_pop_o,
    output logic                       voq_valid_o,
    output logic [PTR_W-1:0]           voq_ptr_o,
    input  logic                       voq_ready_i,
    output logic [GNT_W-1:0]           grant_port_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_EXPIRE = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_MAX    = {WD_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OFFER     = 2'd1,
        WAIT_DROP = 2'd2,
        WAIT_RISE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [GNT_W-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [GNT_W-1:0]  win_idx;
    logic [PTR_W-1:0]  win_ptr;
    logic              win_found;
    logic              accept;
    logic              wd_expire;

`ifdef TX_SCHED_STRICT_PRIO_EN
    // Fixed priority: scan from the top so that the lowest-index valid port is written last and wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                win_found = 1'b1;
                win_idx   = GNT_W'(i);
            end
        end
    end
`else
    logic [GNT_W-1:0]  last_q, last_d;
    logic [GNT_W-1:0]  cand;

    // Round-robin: start the search one port after the last grant, wrap around, and take the first valid port.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = GNT_W'((int'(last_q) + k) % NUM_PORTS);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The last-grant register moves only on accept. Reset makes port 0 the next in line.
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            last_q <= GNT_W'(NUM_PORTS - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Select the head pointer of the winning port.
    always_comb begin
        win_ptr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (GNT_W'(i) == win_idx) begin
                win_ptr = req_ptr_i[i*PTR_W +: PTR_W];
            end
        end
    end

    // Next state, offer latch, watchdog, and accept/expiry strobes.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        accept    = 1'b0;
        wd_expire = 1'b0;
`ifndef TX_SCHED_STRICT_PRIO_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    ptr_d   = win_ptr;
                    state_d = OFFER;
                end
            end
            // Once an offer is latched it is held, even if the requester withdraws.
            OFFER: begin
                if (voq_ready_i) begin
                    accept  = 1'b1;
                    wd_d    = '0;
                    state_d = WAIT_DROP;
`ifndef TX_SCHED_STRICT_PRIO_EN
                    last_d  = grant_q;
`endif
                end
            end
            WAIT_DROP, WAIT_RISE: begin
                if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
                if (wd_q == WD_EXPIRE) begin
                    wd_expire = 1'b1;
                    state_d   = IDLE;
                end else if (state_q == WAIT_DROP && !voq_ready_i) begin
                    state_d = WAIT_RISE;
                end else if (state_q == WAIT_RISE && voq_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Async reset returns the scheduler to a clean IDLE.
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

    // All outputs are decoded from the registered state, so reset clears them at once.
    assign voq_valid_o  = (state_q == OFFER);
    assign voq_ptr_o    = ptr_q;
    assign grant_port_o = grant_q;
    assign busy_o       = (state_q == WAIT_DROP) || (state_q == WAIT_RISE);
    assign timeout_o    = wd_expire;
    assign req_pop_o    = accept ? (NUM_PORTS'(1) << grant_q) : '0;

endmodule

// File: doc/tx_voq_scheduler.md
TX_VOQ_SCHEDULER -- requirements
Module: tx_voq_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of ingress VOQ requesters (2..16).
REQ-002 The block SHALL have parameter VOQ_DEPTH, default 64; PTR_W = $clog2(VOQ_DEPTH).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 4096, giving the maximum switch_clk cycles one frame may hold the egress port.
REQ-004 The block SHALL have these ports:
  switch_clk  in  1  single clock.
  switch_rst_n  in  1  reset, asynchronous, active-low.
  req_valid_i  in  NUM_PORTS  per-ingress VOQ head valid.
  req_ptr_i  in  NUM_PORTS*PTR_W  per-ingress head pointer, packed with port i at [i*PTR_W +: PTR_W].
  req_pop_o  out  NUM_PORTS  one-hot single-cycle dequeue pulse.
  voq_valid_o  out  1  offer to the TX MAC.
  voq_ptr_o  out  PTR_W  offered start pointer.
  voq_ready_i  in  1  TX MAC ready for a new frame.
  grant_port_o  out  $clog2(NUM_PORTS)  port currently offered or in service.
  busy_o  out  1  frame in service.
  timeout_o  out  1  single-cycle pulse on watchdog expiry.

Function
REQ-005 The FSM SHALL have states IDLE, OFFER, WAIT_DROP and WAIT_RISE, plus default -> IDLE.
REQ-006 IDLE: if any req_valid_i bit is set, the block SHALL select a winner per REQ-007, register its index and pointer, and enter OFFER on the next cycle. Otherwise it SHALL stay in IDLE.
REQ-007 Selection SHALL be round-robin: search from (last_grant+1) mod NUM_PORTS upward with wrap-around. The first set bit wins.
REQ-008 In OFFER, voq_valid_o SHALL be 1, and voq_ptr_o and grant_port_o SHALL hold the registered values, unchanged until accept.
REQ-009 Accept SHALL occur on a cycle where voq_valid_o=1 and voq_ready_i=1. On that cycle the block SHALL:
  pulse req_pop_o[grant] for exactly 1 cycle;
  update last_grant to grant;
  enter WAIT_DROP on the next cycle.
REQ-010 A latched offer SHALL NOT be withdrawn or re-arbitrated, even if req_valid_i[grant] deasserts before accept.
REQ-011 In WAIT_DROP, voq_valid_o SHALL be 0 and busy_o SHALL be 1. The block SHALL move to WAIT_RISE on the first cycle where voq_ready_i=0.
REQ-012 In WAIT_RISE, busy_o SHALL be 1. The block SHALL move to IDLE on the first cycle where voq_ready_i=1 (frame plus IFG complete).
REQ-013 The minimum gap from one accept to the next voq_valid_o assertion SHALL be 3 cycles after ready rises: WAIT_RISE -> IDLE -> OFFER.
REQ-014 A watchdog counter SHALL clear on accept and increment each cycle in WAIT_DROP or WAIT_RISE, saturating.
REQ-015 When the watchdog counter reaches TIMEOUT_CYC-1, the block SHALL pulse timeout_o for 1 cycle and force IDLE. last_grant SHALL keep its post-accept value.
REQ-016 busy_o SHALL be 0 in IDLE and OFFER.
REQ-017 req_pop_o SHALL be all-zero except on the accept cycle.

Reset
REQ-018 Asserting switch_rst_n low SHALL immediately force all of the following, at any time including mid-frame:
  state = IDLE;
  voq_valid_o = 0, voq_ptr_o = 0, grant_port_o = 0;
  req_pop_o = 0, busy_o = 0, timeout_o = 0;
  watchdog counter = 0;
  last_grant = NUM_PORTS-1, so port 0 has first priority.
REQ-019 A reset asserted during OFFER SHALL NOT generate any req_pop_o pulse.

Configuration
REQ-020 When macro TX_SCHED_STRICT_PRIO_EN is defined, REQ-007 SHALL be replaced by fixed priority: the lowest-index valid port always wins, and last_grant is unused.
REQ-021 When TX_SCHED_STRICT_PRIO_EN is undefined, round-robin per REQ-007 SHALL apply. All other behaviour SHALL be identical in both builds.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  Single requester: req_valid_i=0001, ptr0=5, ready=1 -> voq_valid_o in OFFER with voq_ptr_o=5; req_pop_o=0001 on the accept cycle; busy_o=1 until ready falls then rises.
  Round-robin fairness: all 4 ports always valid, TX MAC frame time 20 cycles -> grant order 0,1,2,3,0; exactly one pop per frame.
  Strict priority (TX_SCHED_STRICT_PRIO_EN defined): ports 0 and 2 always valid -> port 0 granted on every frame; port 2 never granted.
  Withdrawal: port 1 offered, req_valid_i[1] drops before ready -> offer held; pop for port 1 still issued on accept.
  Watchdog: TIMEOUT_CYC=16, ready held 0 after accept -> timeout_o pulses 16 cycles after accept; state returns to IDLE; the next offer is to port last_grant+1.
  Mid-offer reset: reset pulsed during OFFER -> all outputs 0 in the same cycle; no pop; the first grant after reset release goes to port 0.
